// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready output.
// Mid-bit sampling from a down-counter; framing errors and overruns are one-cycle pulses.
module uart_rx_byte #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = (DIV > 4) ? $clog2(DIV) : 2;
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx_byte: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
    end
  endgenerate

  // state     | meaning
  // IDLE      | line idle, waiting for rxs=0
  // START     | counting to mid start bit, glitch check
  // DATA      | sampling 8 data bits LSB first
  // STOP      | sampling the stop bit
  // WAIT_IDLE | after a framing error, waiting for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta, rxs;
  logic          sample, byte_done, stop_bad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    sample    = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (!rxs) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end
      end
      START: begin
        if (sample) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL_LD;
            bit_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (sample) begin
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      out_data      <= 8'h00;
      out_valid     <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rxs           <= rx_meta;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      framing_error <= stop_bad;
      overrun       <= 1'b0;
      // A byte completing while the old one is being taken replaces it without loss.
      if (byte_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift_q;
          out_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frame-level reference model checked every cycle,
// plus literal expectations for latency, data and pulse counts.
module tb_uart_rx_byte;

  localparam int CLK_F = 16_000_000;
  localparam int BAUD  = 1_000_000;
  localparam int DIV   = CLK_F / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int HMAX  = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       framing_error;
  logic       overrun;

  uart_rx_byte #(.CLOCK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line history and frame-level model: a frame is decoded from the stored
  // synchronized-line history at its fixed sample instants.
  bit   rx_h [HMAX];
  bit   rst_h[HMAX];
  bit   rxs_h[HMAX];
  int   mode = 0;
  int   t0 = 0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;

  int   vrise = 0, ferr_n = 0, ovr_n = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    int c;
    bit s;
    logic [7:0] b;
    bit deliver, nf, no;
    c = cyc;
    if (c >= 1) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      check("out_data", {24'b0, out_data}, {24'b0, exp_data});
      check("framing_error", {31'b0, framing_error}, {31'b0, exp_ferr});
      check("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
      if (out_valid === 1'b1 && !prev_valid) begin
        vrise++;
        rise_cyc  = c;
        rise_data = out_data;
      end
      if (out_valid !== 1'b1 && prev_valid) fall_cyc = c;
      prev_valid = (out_valid === 1'b1);
      if (framing_error === 1'b1) ferr_n++;
      if (overrun === 1'b1) ovr_n++;
    end
    if (c < HMAX) begin
      rx_h[c]  = rx;
      rst_h[c] = rst;
      if (c < 2) s = 1'b1;
      else if (rst_h[c-1] || rst_h[c-2]) s = 1'b1;
      else s = rx_h[c-2];
      rxs_h[c] = s;
      deliver = 1'b0; nf = 1'b0; no = 1'b0; b = 8'h00;
      if (rst) begin
        mode      = 0;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
      end else begin
        case (mode)
          0: if (!s) begin t0 = c; mode = 1; end
          1: begin
            if (c == t0 + HALF && s) mode = 0;
            else if (c == t0 + HALF + 9 * DIV) begin
              for (int k = 0; k < 8; k++) b[k] = rxs_h[t0 + HALF + (k + 1) * DIV];
              if (s) begin deliver = 1'b1; mode = 0; end
              else begin nf = 1'b1; mode = 2; end
            end
          end
          default: if (s) mode = 0;
        endcase
        if (deliver) begin
          if (!exp_valid || out_ready) begin
            exp_data  = b;
            exp_valid = 1'b1;
          end else no = 1'b1;
        end else if (exp_valid && out_ready) exp_valid = 1'b0;
      end
      exp_ferr = nf;
      exp_ovr  = no;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int ready_off, output int e);
    int bi;
    e = cyc;
    for (int i = 0; i < 10 * DIV; i++) begin
      bi = i / DIV;
      if (bi == 0) rx = 1'b0;
      else if (bi <= 8) rx = d[bi-1];
      else rx = stop;
      if (ready_off >= 0) out_ready = (i == ready_off);
      tick();
    end
  endtask

  int e, n0, f0, o0;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // single frame, consumer always ready
    out_ready = 1'b1;
    n0 = vrise; f0 = ferr_n; o0 = ovr_n;
    send_frame(8'hA5, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t1_rises", vrise - n0, 1);
    check("t1_latency", rise_cyc - e, 155);
    check("t1_data", {24'b0, rise_data}, 32'h0000_00A5);
    check("t1_drop", fall_cyc - rise_cyc, 1);
    check("t1_pulses", (ferr_n - f0) + (ovr_n - o0), 0);

    // back-to-back frames with consumer stalled
    out_ready = 1'b0;
    n0 = vrise; o0 = ovr_n;
    send_frame(8'h3C, 1'b1, -1, e);
    send_frame(8'hC3, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t2_overrun", ovr_n - o0, 1);
    check("t2_held", {24'b0, out_data}, 32'h0000_003C);
    check("t2_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_cleared", {31'b0, out_valid}, 32'd0);
    check("t2_rises", vrise - n0, 1);

    // bad stop bit, line held low three bit times
    out_ready = 1'b1;
    n0 = vrise; f0 = ferr_n;
    send_frame(8'h55, 1'b0, -1, e);
    repeat (2 * DIV) tick();
    rx = 1'b1;
    repeat (DIV) tick();
    check("t3_ferr", ferr_n - f0, 1);
    check("t3_no_valid", vrise - n0, 0);
    send_frame(8'h81, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t3_next_data", {24'b0, rise_data}, 32'h0000_0081);
    check("t3_next_rises", vrise - n0, 1);

    // 4-cycle glitch, then a frame starting as soon as the receiver is idle again
    n0 = vrise; f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (6) tick();
    send_frame(8'h42, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t4_rises", vrise - n0, 1);
    check("t4_data", {24'b0, rise_data}, 32'h0000_0042);
    check("t4_latency", rise_cyc - e, 155);
    check("t4_pulses", (ferr_n - f0) + (ovr_n - o0), 0);

    // reset pulse during data bit 4 of 0xFF
    n0 = vrise; f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    repeat (DIV) tick();
    rx = 1'b1;
    repeat (4 * DIV + HALF) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6 * DIV) tick();
    send_frame(8'h12, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t5_rises", vrise - n0, 1);
    check("t5_data", {24'b0, rise_data}, 32'h0000_0012);
    check("t5_pulses", (ferr_n - f0) + (ovr_n - o0), 0);

    // completion on the same cycle the held byte is accepted
    out_ready = 1'b0;
    n0 = vrise; o0 = ovr_n;
    send_frame(8'h66, 1'b1, -1, e);
    rx = 1'b1;
    repeat (4) tick();
    check("t6_held", {24'b0, out_data}, 32'h0000_0066);
    send_frame(8'h77, 1'b1, 154, e);
    out_ready = 1'b0;
    rx = 1'b1;
    repeat (2) tick();
    check("t6_valid", {31'b0, out_valid}, 32'd1);
    check("t6_data", {24'b0, out_data}, 32'h0000_0077);
    check("t6_overrun", ovr_n - o0, 0);
    check("t6_rises", vrise - n0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
